// File: rtl/memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : memory_pkg
// Description : Shared constants and types for the core's memories
// Revision    : 1.1 - wait-state data memory support
// ============================================================================
package memory_pkg;

    localparam int DATA_MEM_SIZE_BYTES  = 2048;
    localparam int DATA_MEM_WAIT_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/data_mem_wait.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_wait
// Description : Word-organised data RAM with byte-lane writes, a programmable
//               number of wait states and a request/ready handshake
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_wait
    import memory_pkg::*;
#(
    parameter int    SIZE_BYTES  = DATA_MEM_SIZE_BYTES,
    parameter int    WAIT_CYCLES = DATA_MEM_WAIT_CYCLES,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o
);

    localparam int c_AW    = $clog2(SIZE_BYTES);
    // Keep the index at least one bit wide so a 4-byte memory still elaborates
    localparam int c_IW    = (c_AW > 2) ? (c_AW - 2) : 1;
    localparam int c_DEPTH = 1 << c_IW;

    logic [31:0]     r_mem [c_DEPTH];

    mem_state_t      r_state;
    mem_state_t      w_next;
    logic [3:0]      r_cnt;
    logic [c_IW-1:0] r_idx;
    logic            r_we;
    logic [3:0]      r_be;
    logic [31:0]     r_wd;
    logic [31:0]     r_rdata;
    logic            r_ready;

    logic [c_IW-1:0] w_idx_in;
    logic [c_IW-1:0] w_idx;
    logic            w_we;
    logic [3:0]      w_be;
    logic [31:0]     w_wd;
    logic            w_commit;
    logic            w_unused_addr;

    // Word index from the byte address; high bits and byte offset are dropped
    generate
        if (c_AW > 2) begin : g_idx_wide
            assign w_idx_in = addr_i[c_AW-1:2];
        end else begin : g_idx_narrow
            assign w_idx_in = '0;
        end
    endgenerate

    assign w_unused_addr = ^{addr_i[31:c_AW], addr_i[1:0]};

    // With zero wait states the commit happens on the acceptance edge itself,
    // so the live inputs are used; otherwise the latched request is used
    assign w_idx = (r_state == IDLE) ? w_idx_in       : r_idx;
    assign w_we  = (r_state == IDLE) ? write_enable_i : r_we;
    assign w_be  = (r_state == IDLE) ? byte_enable_i  : r_be;
    assign w_wd  = (r_state == IDLE) ? write_data_i   : r_wd;

    // Next-state decode; w_commit marks the edge that enters RESP
    always_comb begin
        w_next   = r_state;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_req_i) begin
                    if (WAIT_CYCLES > 0) begin
                        w_next = WAIT;
                    end else begin
                        w_next   = RESP;
                        w_commit = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_next   = RESP;
                    w_commit = 1'b1;
                end
            end
            RESP: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Control state, wait counter, registered ready and read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_rdata <= 32'd0;
        end else begin
            r_state <= w_next;
            r_ready <= (r_state == RESP);
            if (r_state == IDLE && mem_req_i) begin
                r_cnt <= 4'(WAIT_CYCLES);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit && !w_we) begin
                r_rdata <= r_mem[w_idx];
            end
        end
    end

    // Capture the accepted request; later input changes cannot disturb it
    always_ff @(posedge clk_i) begin
        if (r_state == IDLE && mem_req_i) begin
            r_idx <= w_idx_in;
            r_we  <= write_enable_i;
            r_be  <= byte_enable_i;
            r_wd  <= write_data_i;
        end
    end

    // Byte-lane write into the array; reset drops any commit on the same edge
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_commit && w_we) begin
            for (int k = 0; k < 4; k++) begin
                if (w_be[k]) begin
                    r_mem[w_idx][8*k +: 8] <= w_wd[8*k +: 8];
                end
            end
        end
    end

    assign read_data_o = r_rdata;
    assign ready_o     = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_wait.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_wait
// Description : Directed self-checking bench for data_mem_wait; instance 0
//               has two wait states, instance 1 has none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_wait;

    logic             clk;
    logic [1:0]       rst;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [1:0][3:0]  be;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wd;
    logic [1:0][31:0] rdata;
    logic [1:0]       rdy;

    int n_vec = 0;
    int n_err = 0;

    data_mem_wait #(.SIZE_BYTES(2048), .WAIT_CYCLES(2), .INIT_FILE("")) u_a (
        .clk_i(clk), .rst_i(rst[0]), .mem_req_i(req[0]), .write_enable_i(we[0]),
        .byte_enable_i(be[0]), .addr_i(addr[0]), .write_data_i(wd[0]),
        .read_data_o(rdata[0]), .ready_o(rdy[0])
    );

    data_mem_wait #(.SIZE_BYTES(2048), .WAIT_CYCLES(0), .INIT_FILE("")) u_b (
        .clk_i(clk), .rst_i(rst[1]), .mem_req_i(req[1]), .write_enable_i(we[1]),
        .byte_enable_i(be[1]), .addr_i(addr[1]), .write_data_i(wd[1]),
        .read_data_o(rdata[1]), .ready_o(rdy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access from a negedge; returns at the negedge inside the ready cycle
    task automatic access(input int k, input logic w, input logic [3:0] b,
                          input logic [31:0] a, input logic [31:0] d,
                          input int exp_lat, input logic chk_rd,
                          input logic [31:0] exp_rd, input string tag);
        int lat;
        lat = 0;
        req[k] = 1'b1; we[k] = w; be[k] = b; addr[k] = a; wd[k] = d;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) req[k] = 1'b0;
            if (rdy[k]) begin
                lat = c;
                break;
            end
        end
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (chk_rd) chk({tag, "_rd"}, rdata[k], exp_rd);
    endtask

    initial begin
        int pulses;
        int lat;
        rst = 2'b11; req = 2'b11; we = 2'b11; be = '1; addr = '0; wd = '1;

        // Reset held with a request pending: outputs stay cleared
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rst_rdy%0d_c%0d", k, c), 32'(rdy[k]), 32'd0);
                chk($sformatf("rst_rd%0d_c%0d", k, c), rdata[k], 32'd0);
            end
        end
        rst = 2'b00; req = 2'b00; we = 2'b00;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pulses += int'(rdy[0]) + int'(rdy[1]);
        end
        chk("rst_no_accept", 32'(pulses), 32'd0);

        // Full write then read, two wait states
        access(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, 4, 1'b0, 32'h0, "wr_full");
        access(0, 1'b0, 4'b0000, 32'h10, 32'h0, 4, 1'b1, 32'hDEADBEEF, "rd_full");

        // Lanes 0 and 2 only
        access(0, 1'b1, 4'b0101, 32'h10, 32'h11223344, 4, 1'b0, 32'h0, "wr_part");
        access(0, 1'b0, 4'b1111, 32'h10, 32'h0, 4, 1'b1, 32'hDE22BE44, "rd_part");

        // Empty lane mask still handshakes but writes nothing
        access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 4, 1'b0, 32'h0, "wr_be0");
        access(0, 1'b0, 4'b0000, 32'h10, 32'h0, 4, 1'b1, 32'hDE22BE44, "rd_be0");

        // Address wrap and ignored byte offset
        access(0, 1'b1, 4'b1111, 32'h0000_0810, 32'hA5A5A5A5, 4, 1'b0, 32'h0, "wr_wrap");
        access(0, 1'b0, 4'b0000, 32'h10, 32'h0, 4, 1'b1, 32'hA5A5A5A5, "rd_wrap10");
        access(0, 1'b0, 4'b0000, 32'h12, 32'h0, 4, 1'b1, 32'hA5A5A5A5, "rd_wrap12");
        access(0, 1'b0, 4'b0000, 32'h13, 32'h0, 4, 1'b1, 32'hA5A5A5A5, "rd_wrap13");

        // Read data holds through writes and idle cycles
        access(0, 1'b1, 4'b1111, 32'h20, 32'h0, 4, 1'b1, 32'hA5A5A5A5, "hold_wr20");
        access(0, 1'b1, 4'b1111, 32'h34, 32'h11111111, 4, 1'b1, 32'hA5A5A5A5, "hold_wr34");
        repeat (3) @(negedge clk);
        chk("hold_idle", rdata[0], 32'hA5A5A5A5);

        // Inputs move during WAIT and the request stays high through RESP
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b1111; addr[0] = 32'h30; wd[0] = 32'hCAFEF00D;
        @(posedge clk);
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            addr[0] = 32'h34; wd[0] = 32'h0BADF00D; we[0] = 1'b1; be[0] = 4'b0011;
            if (rdy[0]) begin
                lat = c;
                break;
            end
        end
        req[0] = 1'b0;
        chk("stab_lat", 32'(lat), 32'd4);
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            pulses += int'(rdy[0]);
        end
        chk("stab_one_pulse", 32'(pulses), 32'd0);
        access(0, 1'b0, 4'b0000, 32'h30, 32'h0, 4, 1'b1, 32'hCAFEF00D, "stab_rd30");
        access(0, 1'b0, 4'b0000, 32'h34, 32'h0, 4, 1'b1, 32'h11111111, "stab_rd34");

        // Reset during WAIT aborts the write
        req[0] = 1'b1; we[0] = 1'b1; be[0] = 4'b1111; addr[0] = 32'h20; wd[0] = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req[0] = 1'b0; rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("abort_rd_clr", rdata[0], 32'd0);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            pulses += int'(rdy[0]);
        end
        chk("abort_no_rdy", 32'(pulses), 32'd0);
        access(0, 1'b0, 4'b0000, 32'h20, 32'h0, 4, 1'b1, 32'h0, "abort_rd20");

        // Zero wait states: two-cycle latency
        access(1, 1'b1, 4'b1111, 32'h20, 32'h0, 2, 1'b0, 32'h0, "b_wr20");
        access(1, 1'b1, 4'b1111, 32'h40, 32'h55AA55AA, 2, 1'b0, 32'h0, "b_wr40");
        access(1, 1'b0, 4'b0000, 32'h40, 32'h0, 2, 1'b1, 32'h55AA55AA, "b_rd40");

        // Reset on the RESP-entry edge drops the write
        req[1] = 1'b1; we[1] = 1'b1; be[1] = 4'b1111; addr[1] = 32'h20; wd[1] = 32'h12345678;
        rst[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst[1] = 1'b0; req[1] = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            pulses += int'(rdy[1]);
        end
        chk("b_abort_no_rdy", 32'(pulses), 32'd0);
        access(1, 1'b0, 4'b0000, 32'h20, 32'h0, 2, 1'b1, 32'h0, "b_abort_rd20");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
